// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy display path: coordinate width, ground row bound,
// 4-bit reference colours and the hit-flash state type.
package flappy_pkg;

  localparam int COORD_W      = 10;
  localparam int SKYBOUND_DEF = 450;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb4_t;

  localparam rgb4_t SKY      = {4'd6, 4'd7,  4'd15};
  localparam rgb4_t GROUND_A = {4'd1, 4'd15, 4'd2};
  localparam rgb4_t GROUND_B = {4'd1, 4'd11, 4'd2};
  localparam rgb4_t PIPE     = {4'd9, 4'd6,  4'd0};
  localparam rgb4_t BALL_OK  = {4'd15, 4'd15, 4'd0};
  localparam rgb4_t BALL_HIT = {4'd15, 4'd0,  4'd0};

  typedef enum logic {
    FLASH_IDLE,
    FLASH_ACTIVE
  } flash_state_t;

endpackage

// File: rtl/pipe_hit.sv
// Combinational coverage test for one pipe pair against the current pixel.
// Column edges are widened to 11 bits so a pipe near column 1023 never wraps onto column 0.
module pipe_hit
  import flappy_pkg::*;
#(
  parameter int PIPE_W   = 40,
  parameter int SKYBOUND = SKYBOUND_DEF
) (
  input  logic [9:0] pipe_x,
  input  logic [9:0] gap_top,
  input  logic [9:0] gap_bot,
  input  logic       en,
  input  logic [9:0] h,
  input  logic [9:0] v,
  output logic       hit
);

  logic [10:0] x_end;
  logic        in_col;
  logic        in_upper;
  logic        in_lower;

  assign x_end    = {1'b0, pipe_x} + 11'(PIPE_W);
  assign in_col   = ({1'b0, h} >= {1'b0, pipe_x}) && ({1'b0, h} < x_end);
  assign in_upper = v < gap_top;
  assign in_lower = (v >= gap_bot) && ({1'b0, v} <= 11'(SKYBOUND));
  assign hit      = en && in_col && (in_upper || in_lower);

endmodule

// File: rtl/layered_renderer.sv
// Layered pixel renderer: player, NUM_PIPES pipe pairs, scrolling striped ground and sky,
// drawn from per-frame shadow copies through a 2-stage registered pipeline.
module layered_renderer
  import flappy_pkg::*;
#(
  parameter int NUM_PIPES    = 2,
  parameter int COLOR_W      = 4,
  parameter int BALL_XSIZE   = 20,
  parameter int BALL_YSIZE   = 20,
  parameter int PIPE_W       = 40,
  parameter int SKYBOUND     = SKYBOUND_DEF,
  parameter int STRIPE_W     = 16,
  parameter int FLASH_FRAMES = 60
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      vidon,
  input  logic [9:0]                h_counter,
  input  logic [9:0]                v_counter,
  input  logic [9:0]                ballX,
  input  logic [9:0]                ballY,
  input  logic [10*NUM_PIPES-1:0]   pipeX,
  input  logic [10*NUM_PIPES-1:0]   gapTop,
  input  logic [10*NUM_PIPES-1:0]   gapBot,
  input  logic [NUM_PIPES-1:0]      pipe_en,
  input  logic [15:0]               status,
  output logic [COLOR_W-1:0]        red,
  output logic [COLOR_W-1:0]        green,
  output logic [COLOR_W-1:0]        blue
);

  // Counter is kept at least 3 bits wide because bit 2 drives the blink.
  localparam int FLASH_W = ($clog2(FLASH_FRAMES + 1) < 3) ? 3 : $clog2(FLASH_FRAMES + 1);

  function automatic logic [COLOR_W-1:0] scale(input logic [3:0] c);
    logic [COLOR_W-1:0] o;
    o = '0;
    for (int i = 0; i < COLOR_W; i++) o[COLOR_W-1-i] = c[3-(i%4)];
    return o;
  endfunction

  coord_t                    ball_x_s, ball_y_s;
  logic [10*NUM_PIPES-1:0]   pipe_x_s, gap_top_s, gap_bot_s;
  logic [NUM_PIPES-1:0]      pipe_en_s;
  coord_t                    scroll;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball_x_s  <= '0;
      ball_y_s  <= '0;
      pipe_x_s  <= '0;
      gap_top_s <= '0;
      gap_bot_s <= '0;
      pipe_en_s <= '0;
      scroll    <= '0;
    end else if (frame_start) begin
      ball_x_s  <= ballX;
      ball_y_s  <= ballY;
      pipe_x_s  <= pipeX;
      gap_top_s <= gapTop;
      gap_bot_s <= gapBot;
      pipe_en_s <= pipe_en;
      if (!status[1] && !status[2]) scroll <= scroll + 10'd1;
    end
  end

  flash_state_t         state, state_next;
  logic [FLASH_W-1:0]   flash_cnt, cnt_next;
  logic                 hit_prev;
  logic                 hit_rise;
  logic                 blink_off;

  assign hit_rise = status[0] && !hit_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FLASH_IDLE;
      flash_cnt <= '0;
      hit_prev  <= 1'b0;
    end else begin
      state     <= state_next;
      flash_cnt <= cnt_next;
      hit_prev  <= status[0];
    end
  end

  // A fresh hit edge reloads the blink even when it coincides with a frame tick.
  always_comb begin
    cnt_next = flash_cnt;
    if (hit_rise)
      cnt_next = FLASH_W'(FLASH_FRAMES);
    else if (frame_start && state == FLASH_ACTIVE)
      cnt_next = flash_cnt - 1'b1;
    state_next = (cnt_next != '0) ? FLASH_ACTIVE : FLASH_IDLE;
  end

  always_comb begin
    blink_off = (state == FLASH_ACTIVE) && flash_cnt[2];
  end

  logic [NUM_PIPES-1:0] pipe_hits;

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    pipe_hit #(
      .PIPE_W  (PIPE_W),
      .SKYBOUND(SKYBOUND)
    ) u_pipe_hit (
      .pipe_x (pipe_x_s[10*i +: 10]),
      .gap_top(gap_top_s[10*i +: 10]),
      .gap_bot(gap_bot_s[10*i +: 10]),
      .en     (pipe_en_s[i]),
      .h      (h_counter),
      .v      (v_counter),
      .hit    (pipe_hits[i])
    );
  end

  logic   ball_hit;
  logic   ground_hit;
  coord_t stripe_sum;

  assign ball_hit = !blink_off
                 && ({1'b0, h_counter} >= {1'b0, ball_x_s})
                 && ({1'b0, h_counter} <  {1'b0, ball_x_s} + 11'(BALL_XSIZE))
                 && ({1'b0, v_counter} >= {1'b0, ball_y_s})
                 && ({1'b0, v_counter} <  {1'b0, ball_y_s} + 11'(BALL_YSIZE));
  assign ground_hit = {1'b0, v_counter} > 11'(SKYBOUND);
  assign stripe_sum = h_counter + scroll;

  logic s1_vid, s1_ball, s1_pipe, s1_ground, s1_stripe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vid    <= 1'b0;
      s1_ball   <= 1'b0;
      s1_pipe   <= 1'b0;
      s1_ground <= 1'b0;
      s1_stripe <= 1'b0;
    end else begin
      s1_vid    <= vidon;
      s1_ball   <= ball_hit;
      s1_pipe   <= |pipe_hits;
      s1_ground <= ground_hit;
      s1_stripe <= |(stripe_sum & 10'(STRIPE_W));
    end
  end

  rgb4_t colour;

  always_comb begin
    colour = SKY;
    if (s1_ball)        colour = (status[1] || status[0]) ? BALL_HIT : BALL_OK;
    else if (s1_pipe)   colour = PIPE;
    else if (s1_ground) colour = s1_stripe ? GROUND_A : GROUND_B;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (!s1_vid) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= scale(colour.r);
      green <= scale(colour.g);
      blue  <= scale(colour.b);
    end
  end

  logic unused_status;
  assign unused_status = ^status[15:3];

endmodule

// File: tb/tb_layered_renderer.sv
// Self-checking bench for layered_renderer: directed scenarios plus randomized frames
// compared against a rule-level colour model.
module tb_layered_renderer;

  localparam int NP     = 2;
  localparam int FLASH  = 60;

  localparam logic [11:0] C_BLACK = 12'h000;
  localparam logic [11:0] C_SKY   = 12'h67F;
  localparam logic [11:0] C_PIPE  = 12'h960;
  localparam logic [11:0] C_OK    = 12'hFF0;
  localparam logic [11:0] C_HIT   = 12'hF00;
  localparam logic [11:0] C_GA    = 12'h1F2;
  localparam logic [11:0] C_GB    = 12'h1B2;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic              vidon;
  logic [9:0]        h_counter, v_counter, ballX, ballY;
  logic [10*NP-1:0]  pipeX, gapTop, gapBot;
  logic [NP-1:0]     pipe_en;
  logic [15:0]       status;
  logic [3:0]        red, green, blue;

  int checks   = 0;
  int failures = 0;

  int          m_bx, m_by, m_scroll, m_flash;
  int          m_px[NP], m_gt[NP], m_gb[NP];
  bit          m_en[NP];
  logic [15:0] m_status;

  layered_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .vidon      (vidon),
    .h_counter  (h_counter),
    .v_counter  (v_counter),
    .ballX      (ballX),
    .ballY      (ballY),
    .pipeX      (pipeX),
    .gapTop     (gapTop),
    .gapBot     (gapBot),
    .pipe_en    (pipe_en),
    .status     (status),
    .red        (red),
    .green      (green),
    .blue       (blue)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] refColor(int h, int v, bit vid);
    bit hidden;
    if (!vid) return C_BLACK;
    hidden = (m_flash != 0) && (((m_flash >> 2) & 1) == 1);
    if (!hidden && h >= m_bx && h < m_bx + 20 && v >= m_by && v < m_by + 20)
      return (m_status[1] || m_status[0]) ? C_HIT : C_OK;
    for (int i = 0; i < NP; i++)
      if (m_en[i] && h >= m_px[i] && h < m_px[i] + 40 &&
          (v < m_gt[i] || (v >= m_gb[i] && v <= 450)))
        return C_PIPE;
    if (v > 450) return ((((h + m_scroll) / 16) % 2) == 1) ? C_GA : C_GB;
    return C_SKY;
  endfunction

  task automatic modelReset();
    m_bx = 0; m_by = 0; m_scroll = 0; m_flash = 0;
    for (int i = 0; i < NP; i++) begin
      m_px[i] = 0; m_gt[i] = 0; m_gb[i] = 0; m_en[i] = 0;
    end
  endtask

  task automatic modelFrame();
    m_bx = ballX; m_by = ballY;
    for (int i = 0; i < NP; i++) begin
      m_px[i] = pipeX[10*i +: 10];
      m_gt[i] = gapTop[10*i +: 10];
      m_gb[i] = gapBot[10*i +: 10];
      m_en[i] = pipe_en[i];
    end
    if (!m_status[1] && !m_status[2]) m_scroll = (m_scroll + 1) % 1024;
  endtask

  task automatic checkOutput(string tag, logic [11:0] expected);
    logic [11:0] observed;
    observed = {red, green, blue};
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(int h, int v, bit vid);
    @(negedge clk);
    h_counter = 10'(h);
    v_counter = 10'(v);
    vidon     = vid;
  endtask

  task automatic checkPixel(string tag, int h, int v, bit vid, logic [11:0] expected);
    applyStimulus(h, v, vid);
    @(negedge clk);
    @(negedge clk);
    checkOutput(tag, expected);
  endtask

  task automatic framePulse();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    if (m_flash > 0) m_flash--;
    modelFrame();
  endtask

  task automatic setStatus(logic [15:0] s);
    @(negedge clk);
    status = s;
    @(negedge clk);
    if (s[0] && !m_status[0]) m_flash = FLASH;
    m_status = s;
  endtask

  task automatic setPipe(int i, int x, int gt, int gb);
    pipeX[10*i +: 10]  = 10'(x);
    gapTop[10*i +: 10] = 10'(gt);
    gapBot[10*i +: 10] = 10'(gb);
  endtask

  initial begin
    int h, v;
    logic [11:0] first_stripe;

    rst = 1'b1;
    frame_start = 1'b0;
    vidon = 1'b0;
    h_counter = '0; v_counter = '0;
    ballX = '0; ballY = '0;
    pipeX = '0; gapTop = '0; gapBot = '0; pipe_en = '0;
    status = '0;
    m_status = '0;
    modelReset();

    // Outputs stay black while reset is held, whatever the inputs do.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      frame_start = 1'($urandom);
      vidon       = 1'b1;
      h_counter   = 10'($urandom);
      v_counter   = 10'($urandom);
      ballX       = 10'($urandom);
      ballY       = 10'($urandom);
      pipeX       = 20'($urandom);
      gapTop      = 20'($urandom);
      gapBot      = 20'($urandom);
      pipe_en     = 2'($urandom);
      status      = 16'($urandom);
      @(negedge clk);
      checkOutput("reset_black", C_BLACK);
    end

    @(negedge clk);
    frame_start = 1'b0;
    status = '0;
    @(negedge clk);
    rst = 1'b0;

    checkPixel("noframe_ball_origin", 5, 5, 1, C_OK);
    checkPixel("noframe_ball_edge", 19, 19, 1, C_OK);
    checkPixel("noframe_outside", 20, 5, 1, C_SKY);
    checkPixel("noframe_no_pipe", 10, 100, 1, refColor(10, 100, 1));

    ballX = 10'd100; ballY = 10'd200;
    setPipe(0, 300, 150, 260);
    setPipe(1, 500, 0, 0);
    pipe_en = 2'b01;
    framePulse();

    checkPixel("ball_tl", 100, 200, 1, C_OK);
    checkPixel("ball_br", 119, 219, 1, C_OK);
    checkPixel("ball_right_out", 120, 200, 1, C_SKY);
    checkPixel("ball_left_out", 99, 200, 1, C_SKY);

    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(100, 200, 1);
    @(negedge clk);
    checkOutput("latency_1clk", C_BLACK);
    @(negedge clk);
    checkOutput("latency_2clk", C_OK);

    checkPixel("pipe_upper", 310, 100, 1, C_PIPE);
    checkPixel("pipe_gap", 310, 200, 1, C_SKY);
    checkPixel("pipe_lower", 310, 300, 1, C_PIPE);
    checkPixel("pipe_ground", 310, 451, 1, refColor(310, 451, 1));
    checkPixel("pipe_disabled", 510, 100, 1, C_SKY);
    checkPixel("vidon_low", 100, 200, 0, C_BLACK);

    // New positions only take effect at the next frame tick.
    ballX = 10'd400;
    checkPixel("midframe_old_pos", 105, 205, 1, C_OK);
    checkPixel("midframe_new_pos", 405, 205, 1, C_SKY);
    framePulse();
    checkPixel("newframe_old_pos", 105, 205, 1, C_SKY);
    checkPixel("newframe_new_pos", 405, 205, 1, C_OK);

    ballX = 10'd100;
    framePulse();
    setStatus(16'h0001);
    checkPixel("flash_start_hidden", 105, 205, 1, refColor(105, 205, 1));
    for (int f = 0; f < FLASH; f++) begin
      framePulse();
      checkPixel("flash_frame", 105, 205, 1, refColor(105, 205, 1));
    end
    checkPixel("flash_done_red", 105, 205, 1, C_HIT);

    setStatus(16'h0002);
    checkPixel("gameover_red", 105, 205, 1, C_HIT);
    first_stripe = refColor(8, 460, 1);
    for (int f = 0; f < 3; f++) begin
      framePulse();
      checkPixel("frozen_stripe", 8, 460, 1, first_stripe);
    end

    // Hit edge coinciding with a frame tick reloads rather than decrements.
    setStatus(16'h0000);
    @(negedge clk);
    status = 16'h0001;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    m_flash = FLASH;
    m_status = 16'h0001;
    modelFrame();
    checkPixel("hit_and_frame_load", 105, 205, 1, refColor(105, 205, 1));
    checkPixel("hit_and_frame_hidden", 105, 205, 1, C_SKY);

    setStatus(16'h0000);
    for (int f = 0; f < 32; f++) begin
      framePulse();
      checkPixel("ground_scroll", 0, 460, 1, refColor(0, 460, 1));
    end

    ballX = 10'd1015; ballY = 10'd455;
    framePulse();
    for (int x = 0; x < 6; x++)
      checkPixel("no_wrap_ball", x, 460, 1, refColor(x, 460, 1));
    checkPixel("ball_far_right", 1020, 460, 1, refColor(1020, 460, 1));

    // Randomized frames against the model.
    for (int f = 0; f < 30; f++) begin
      ballX = 10'($urandom); ballY = 10'($urandom_range(0, 500));
      for (int i = 0; i < NP; i++)
        setPipe(i, $urandom_range(0, 1023), $urandom_range(0, 400), $urandom_range(100, 520));
      pipe_en = 2'($urandom);
      if ($urandom_range(0, 3) == 0) setStatus(16'($urandom_range(0, 7)));
      framePulse();
      for (int p = 0; p < 6; p++) begin
        bit vid;
        h = $urandom_range(0, 1023);
        v = $urandom_range(0, 520);
        vid = ($urandom_range(0, 7) != 0);
        if (p == 0) begin h = m_bx; v = m_by; end
        checkPixel("random_pixel", h, v, vid, refColor(h, v, vid));
      end
    end

    // Asynchronous reset in the middle of a frame.
    setStatus(16'h0000);
    applyStimulus(300, 100, 1);
    #2 rst = 1'b1;
    #1 checkOutput("midframe_reset_black", C_BLACK);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    checkPixel("post_reset_ball_origin", 5, 5, 1, C_OK);
    checkPixel("post_reset_no_pipe", 310, 100, 1, C_SKY);
    checkPixel("post_reset_ground", 3, 470, 1, refColor(3, 470, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
